// File: rtl/dsdmnist_runctrl.sv
`default_nettype none
//==============================================================================
// Module      : dsdmnist_runctrl
// Description : Run sequencer for the dsdmnist MLP inference engine.
//               Debounces the start switch, launches the engine once per
//               image for IMGNUM images, guards each image with a watchdog,
//               writes each classification into the result buffer, then
//               pulses the ARM interrupt and lights the done LED.
// Ports       : i_CLK / i_RST_n           clock, async active-low reset
//               i_STARTSW                 raw start switch (asynchronous)
//               o_ENG_START/o_ENG_IMGIDX  engine launch strobe + image index
//               i_ENG_DONE/i_ENG_CLASS    engine completion strobe + class
//               o_RESULTBUF_*             result buffer write port
//               o_ARMINT                  IRQLEN-cycle interrupt pulse
//               o_DONELED                 run-complete indicator
//               o_BUSY                    high whenever not idle
// Revision    : 1.0 - initial release
//==============================================================================
module dsdmnist_runctrl #(
    parameter int IMGNUM  = 10,
    parameter int DBCYC   = 16,
    parameter int TIMEOUT = 4096,
    parameter int IRQLEN  = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_STARTSW,
    output logic        o_ENG_START,
    output logic [7:0]  o_ENG_IMGIDX,
    input  logic        i_ENG_DONE,
    input  logic [3:0]  i_ENG_CLASS,
    output logic        o_RESULTBUF_EN,
    output logic        o_RESULTBUF_WE,
    output logic [31:0] o_RESULTBUF_DATA,
    output logic [7:0]  o_RESULTBUF_ADDR,
    output logic        o_ARMINT,
    output logic        o_DONELED,
    output logic        o_BUSY
);

    localparam int c_DBW = $clog2(DBCYC + 1);
    localparam int c_WDW = $clog2(TIMEOUT);
    localparam int c_IRW = (IRQLEN > 1) ? $clog2(IRQLEN) : 1;

    localparam logic [c_DBW-1:0] c_DB_MAX   = c_DBW'(DBCYC);
    localparam logic [c_DBW-1:0] c_DB_PRE   = c_DBW'(DBCYC - 1);
    localparam logic [c_DBW-1:0] c_DB_ONE   = c_DBW'(1);
    localparam logic [c_WDW-1:0] c_WDOG_MAX = c_WDW'(TIMEOUT - 1);
    localparam logic [c_WDW-1:0] c_WDOG_ONE = c_WDW'(1);
    localparam logic [c_IRW-1:0] c_IRQ_MAX  = c_IRW'(IRQLEN - 1);
    localparam logic [c_IRW-1:0] c_IRQ_ONE  = c_IRW'(1);
    localparam logic [7:0]       c_IDX_LAST = 8'(IMGNUM - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LAUNCH = 3'd1;
    localparam logic [2:0] c_S_WAIT   = 3'd2;
    localparam logic [2:0] c_S_WRITE  = 3'd3;
    localparam logic [2:0] c_S_IRQ    = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [c_DBW-1:0] r_dbcnt;
    logic             r_start_acc;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [7:0]       r_idx;
    logic [c_WDW-1:0] r_wdog;
    logic [c_IRW-1:0] r_irqcnt;
    logic [3:0]       r_class;
    logic             r_tflag;
    logic             r_doneled;
    logic             w_rflag;

    // Two-flop synchronizer for the asynchronous switch.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_STARTSW;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the counter saturates at DBCYC, so the accept pulse fires
    // exactly once per high period and rearms only when the switch drops.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_dbcnt     <= '0;
            r_start_acc <= 1'b0;
        end else begin
            r_start_acc <= r_sync2 && (r_dbcnt == c_DB_PRE);
            if (!r_sync2) begin
                r_dbcnt <= '0;
            end else if (r_dbcnt != c_DB_MAX) begin
                r_dbcnt <= r_dbcnt + c_DB_ONE;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; in WAIT a completion strobe takes priority
    // over watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (r_start_acc) w_state_nxt = c_S_LAUNCH;
            c_S_LAUNCH: w_state_nxt = c_S_WAIT;
            c_S_WAIT:   if (i_ENG_DONE || (r_wdog == c_WDOG_MAX)) w_state_nxt = c_S_WRITE;
            c_S_WRITE:  w_state_nxt = (r_idx == c_IDX_LAST) ? c_S_IRQ : c_S_LAUNCH;
            c_S_IRQ:    if (r_irqcnt == c_IRQ_MAX) w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    // Datapath registers updated per state
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_idx     <= 8'd0;
            r_wdog    <= '0;
            r_irqcnt  <= '0;
            r_class   <= 4'd0;
            r_tflag   <= 1'b0;
            r_doneled <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (r_start_acc) begin
                        r_doneled <= 1'b0;
                        r_idx     <= 8'd0;
                    end
                end
                c_S_LAUNCH: begin
                    r_wdog <= '0;
                end
                c_S_WAIT: begin
                    if (i_ENG_DONE) begin
                        r_class <= i_ENG_CLASS;
                        r_tflag <= 1'b0;
                    end else if (r_wdog == c_WDOG_MAX) begin
                        r_class <= 4'hF;
                        r_tflag <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + c_WDOG_ONE;
                    end
                end
                c_S_WRITE: begin
                    if (r_idx == c_IDX_LAST) begin
                        r_doneled <= 1'b1;
                        r_irqcnt  <= '0;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                c_S_IRQ: begin
                    r_irqcnt <= r_irqcnt + c_IRQ_ONE;
                end
                default: ;
            endcase
        end
    end

    // Out-of-range class flag, suppressed for watchdog results
    assign w_rflag = (r_class > 4'd9) && !r_tflag;

    // FSM outputs; r_idx only changes on the edge into LAUNCH, so it holds
    // the launched index until the next launch.
    always_comb begin
        o_ENG_START      = 1'b0;
        o_ENG_IMGIDX     = r_idx;
        o_RESULTBUF_EN   = 1'b0;
        o_RESULTBUF_WE   = 1'b0;
        o_RESULTBUF_DATA = 32'd0;
        o_RESULTBUF_ADDR = 8'd0;
        o_ARMINT         = 1'b0;
        o_DONELED        = r_doneled;
        o_BUSY           = (r_state != c_S_IDLE);
        case (r_state)
            c_S_LAUNCH: o_ENG_START = 1'b1;
            c_S_WRITE: begin
                o_RESULTBUF_EN   = 1'b1;
                o_RESULTBUF_WE   = 1'b1;
                o_RESULTBUF_ADDR = r_idx;
                o_RESULTBUF_DATA = {r_tflag, w_rflag, 26'd0, r_class};
            end
            c_S_IRQ:    o_ARMINT = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
